// File: rtl/mc_bus_pkg.sv
// Shared parameters, FSM state encoding and register address map for the
// MCU parallel-bus responder.
package mc_bus_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADD_WIDTH  = 6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_READ_REQ   = 3'd2,
    ST_READ_WAIT  = 3'd3,
    ST_READ_DRIVE = 3'd4
  } mc_state_e;

  typedef enum logic [5:0] {
    REG_IO_ODOE   = 6'h00,
    REG_IO_HLDIR  = 6'h01,
    REG_SRAM_DATA = 6'h02,
    REG_SRAM_CTRL = 6'h03,
    REG_LA_COUNT  = 6'h04,
    REG_PWM_A     = 6'h05,
    REG_PWM_B     = 6'h06
  } mc_reg_addr_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an active-low strobe, plus one edge-detect stage.
// All stages reset to 1 so a strobe still held low after reset reads as a fresh fall.
module sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_r;
  logic       last_r;

  // synchroniser chain and edge-detect history
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= 2'b11;
      last_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], d};
      last_r <= sync_r[1];
    end
  end

  assign q    = sync_r[1];
  assign rise = sync_r[1] & ~last_r;
  assign fall = ~sync_r[1] & last_r;

endmodule

// File: rtl/mc_bus_responder.sv
// MCU parallel-bus responder: turns synchronised write cycles into one-clock
// register write strobes and read cycles into one-clock read requests.
module mc_bus_responder
  import mc_bus_pkg::*;
#(
  parameter int MC_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MC_ADD_WIDTH  = DEFAULT_ADD_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
  output logic                     reg_wr_en,
  output logic [MC_ADD_WIDTH-1:0]  reg_wr_addr,
  output logic [MC_DATA_WIDTH-1:0] reg_wr_data,
  output logic                     reg_rd_en,
  output logic [MC_ADD_WIDTH-1:0]  reg_rd_addr,
  input  logic [MC_DATA_WIDTH-1:0] reg_rd_data,
  output logic                     bus_err
);

  logic ce_n_s, oe_n_s, we_n_s;
  logic ce_rise_s, ce_fall_s, oe_rise_s, oe_fall_s, we_rise_s, we_fall_s;
  logic unused_edges;

  logic [MC_ADD_WIDTH-1:0]  add_meta_r, add_sync_r, cap_addr_r;
  logic [MC_DATA_WIDTH-1:0] data_meta_r, data_sync_r, cap_data_r, hold_r;

  mc_state_e state_r, state_next_s;
  logic      wr_commit_s, rd_issue_s, overlap_s;
  logic      rd_armed_r, drive_en_r;

  sync_edge u_ce (.clock(clock), .reset(reset), .d(mc_ce), .q(ce_n_s), .rise(ce_rise_s), .fall(ce_fall_s));
  sync_edge u_oe (.clock(clock), .reset(reset), .d(mc_oe), .q(oe_n_s), .rise(oe_rise_s), .fall(oe_fall_s));
  sync_edge u_we (.clock(clock), .reset(reset), .d(mc_we), .q(we_n_s), .rise(we_rise_s), .fall(we_fall_s));

  assign unused_edges = ce_rise_s ^ ce_fall_s ^ oe_rise_s ^ we_fall_s;

  // address and data synchronisers, aligned with the strobe synchronisers
  always_ff @(posedge clock) begin
    if (reset) begin
      add_meta_r  <= {MC_ADD_WIDTH{1'b0}};
      add_sync_r  <= {MC_ADD_WIDTH{1'b0}};
      data_meta_r <= {MC_DATA_WIDTH{1'b0}};
      data_sync_r <= {MC_DATA_WIDTH{1'b0}};
    end else begin
      add_meta_r  <= mc_add;
      add_sync_r  <= add_meta_r;
      data_meta_r <= mc_data;
      data_sync_r <= data_meta_r;
    end
  end

  // next-state and strobe decode
  always_comb begin
    state_next_s = state_r;
    wr_commit_s  = 1'b0;
    rd_issue_s   = 1'b0;
    overlap_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!ce_n_s && !we_n_s) begin
          state_next_s = ST_WRITE;
          overlap_s    = ~oe_n_s;
        end else if (!ce_n_s && !oe_n_s && rd_armed_r) begin
          state_next_s = ST_READ_REQ;
          rd_issue_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (we_rise_s) begin
          state_next_s = ST_IDLE;
          wr_commit_s  = 1'b1;
        end else if (ce_n_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WRITE;
        end
        overlap_s = oe_fall_s;
      end
      ST_READ_REQ:  state_next_s = ST_READ_WAIT;
      ST_READ_WAIT: state_next_s = ST_READ_DRIVE;
      ST_READ_DRIVE: begin
        if (oe_n_s || ce_n_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_READ_DRIVE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // state, registered strobes, capture/hold registers and drive enable
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= {MC_ADD_WIDTH{1'b0}};
      reg_wr_data <= {MC_DATA_WIDTH{1'b0}};
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= {MC_ADD_WIDTH{1'b0}};
      bus_err     <= 1'b0;
      cap_addr_r  <= {MC_ADD_WIDTH{1'b0}};
      cap_data_r  <= {MC_DATA_WIDTH{1'b0}};
      hold_r      <= {MC_DATA_WIDTH{1'b0}};
      rd_armed_r  <= 1'b1;
      drive_en_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      reg_wr_en  <= wr_commit_s;
      reg_rd_en  <= rd_issue_s;
      drive_en_r <= (state_next_s == ST_READ_DRIVE);
      // commit uses the sample from the last cycle we_n was still low
      if ((state_r == ST_IDLE || state_r == ST_WRITE) && !we_n_s) begin
        cap_addr_r <= add_sync_r;
        cap_data_r <= data_sync_r;
      end
      if (wr_commit_s) begin
        reg_wr_addr <= cap_addr_r;
        reg_wr_data <= cap_data_r;
      end
      if (rd_issue_s) begin
        reg_rd_addr <= add_sync_r;
      end
      if (state_r == ST_READ_WAIT) begin
        hold_r <= reg_rd_data;
      end
      if (overlap_s) begin
        bus_err <= 1'b1;
      end
      // one read per oe_n low pulse: re-arm only once oe_n is seen high again
      if (oe_n_s) begin
        rd_armed_r <= 1'b1;
      end else if (rd_issue_s || overlap_s) begin
        rd_armed_r <= 1'b0;
      end
    end
  end

  assign mc_data = drive_en_r ? hold_r : {MC_DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mc_bus_responder.sv
// Directed self-checking bench for mc_bus_responder; the data bus has a
// weak pull-up so a released bus reads as all ones.
module tb_mc_bus_responder;
  import mc_bus_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam logic [DW-1:0] BUS_IDLE = 16'hFFFF;

  logic          clock;
  logic          reset;
  logic          mc_ce, mc_oe, mc_we;
  logic [AW-1:0] mc_add;
  tri1  [DW-1:0] mc_data;
  logic          tb_drv_en;
  logic [DW-1:0] tb_drv;
  logic          reg_wr_en, reg_rd_en, bus_err;
  logic [AW-1:0] reg_wr_addr, reg_rd_addr;
  logic [DW-1:0] reg_wr_data, reg_rd_data, rd_resp;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int wr_base, rd_base;

  mc_bus_responder dut (
    .clock(clock), .reset(reset),
    .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_data(mc_data),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .bus_err(bus_err)
  );

  assign mc_data = tb_drv_en ? tb_drv : {DW{1'bz}};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // register-file model: returns the programmed word one cycle after the request
  always @(posedge clock) begin
    if (reg_rd_en) reg_rd_data <= rd_resp;
  end

  // strobe pulse counters
  always @(posedge clock) begin
    if (reg_wr_en) wr_cnt <= wr_cnt + 1;
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int low);
    mc_ce = 1'b0; mc_add = addr; tb_drv = data; tb_drv_en = 1'b1;
    tick(1);
    mc_we = 1'b0;
    tick(low);
    wr_base = wr_cnt;
    mc_we = 1'b1;
    tick(2);
    check("wr_not_early", {31'd0, reg_wr_en}, 32'd0);
    tick(1);
    check("wr_en", {31'd0, reg_wr_en}, 32'd1);
    check("wr_addr", {26'd0, reg_wr_addr}, {26'd0, addr});
    check("wr_data", {16'd0, reg_wr_data}, {16'd0, data});
    tick(1);
    check("wr_en_one_cycle", {31'd0, reg_wr_en}, 32'd0);
    mc_ce = 1'b1; tb_drv_en = 1'b0;
    tick(4);
    check("wr_count", wr_cnt - wr_base, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] resp, input int low);
    rd_resp = resp; mc_ce = 1'b0; mc_add = addr;
    tick(1);
    rd_base = rd_cnt;
    mc_oe = 1'b0;
    tick(2);
    check("rd_not_early", {31'd0, reg_rd_en}, 32'd0);
    tick(1);
    check("rd_en", {31'd0, reg_rd_en}, 32'd1);
    check("rd_addr", {26'd0, reg_rd_addr}, {26'd0, addr});
    tick(1);
    check("bus_not_early", {16'd0, mc_data}, {16'd0, BUS_IDLE});
    tick(1);
    check("bus_drive", {16'd0, mc_data}, {16'd0, resp});
    tick(low - 5);
    check("bus_held", {16'd0, mc_data}, {16'd0, resp});
    mc_oe = 1'b1;
    tick(2);
    check("bus_hold_after_oe", {16'd0, mc_data}, {16'd0, resp});
    tick(1);
    check("bus_release", {16'd0, mc_data}, {16'd0, BUS_IDLE});
    mc_ce = 1'b1;
    tick(4);
    check("rd_count", rd_cnt - rd_base, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b1;
    mc_add = 6'h00; tb_drv_en = 1'b0; tb_drv = 16'h0000; rd_resp = 16'h0000;
    tick(3);
    check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    check("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
    check("rst_wr_addr", {26'd0, reg_wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, reg_wr_data}, 32'd0);
    check("rst_rd_addr", {26'd0, reg_rd_addr}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_bus", {16'd0, mc_data}, {16'd0, BUS_IDLE});
    reset = 1'b0;
    tick(4);

    do_write(REG_SRAM_CTRL, 16'h001B, 6);
    do_write(REG_IO_ODOE, 16'hBEEF, 4);

    do_read(REG_SRAM_DATA, 16'h00AA, 8);
    do_read(REG_SRAM_DATA, 16'h0055, 8);
    do_read(REG_LA_COUNT, 16'h1357, 200);
    check("no_err_normal", {31'd0, bus_err}, 32'd0);

    // we_n and oe_n together: write wins, no read, sticky error
    mc_ce = 1'b0; mc_add = REG_PWM_A; tb_drv = 16'h1234; tb_drv_en = 1'b1;
    tick(1);
    wr_base = wr_cnt; rd_base = rd_cnt;
    mc_we = 1'b0; mc_oe = 1'b0;
    tick(6);
    mc_we = 1'b1;
    tick(3);
    check("ovl_wr_en", {31'd0, reg_wr_en}, 32'd1);
    check("ovl_wr_addr", {26'd0, reg_wr_addr}, 32'h05);
    check("ovl_wr_data", {16'd0, reg_wr_data}, 32'h1234);
    tick(6);
    check("ovl_bus_err", {31'd0, bus_err}, 32'd1);
    mc_oe = 1'b1;
    tick(4);
    check("ovl_no_read", rd_cnt - rd_base, 32'd0);
    check("ovl_one_write", wr_cnt - wr_base, 32'd1);
    mc_ce = 1'b1; tb_drv_en = 1'b0;
    tick(6);
    check("ovl_err_sticky", {31'd0, bus_err}, 32'd1);

    // reset during READ_DRIVE with oe_n held low
    rd_resp = 16'h0F0F; mc_ce = 1'b0; mc_add = REG_SRAM_DATA;
    tick(1);
    mc_oe = 1'b0;
    tick(6);
    check("rr_pre_drive", {16'd0, mc_data}, 32'h0F0F);
    reset = 1'b1;
    tick(1);
    check("rr_bus_released", {16'd0, mc_data}, {16'd0, BUS_IDLE});
    check("rr_err_cleared", {31'd0, bus_err}, 32'd0);
    check("rr_no_rd_en", {31'd0, reg_rd_en}, 32'd0);
    rd_resp = 16'h3C3C;
    wr_base = wr_cnt; rd_base = rd_cnt;
    reset = 1'b0;
    tick(10);
    check("rr_new_drive", {16'd0, mc_data}, 32'h3C3C);
    check("rr_one_read", rd_cnt - rd_base, 32'd1);
    check("rr_no_write", wr_cnt - wr_base, 32'd0);
    mc_oe = 1'b1; mc_ce = 1'b1;
    tick(6);
    check("rr_bus_idle", {16'd0, mc_data}, {16'd0, BUS_IDLE});

    // single-cycle we_n pulse: never more than one strobe
    mc_ce = 1'b0; mc_add = REG_PWM_B;
    tick(1);
    wr_base = wr_cnt;
    mc_we = 1'b0;
    tick(1);
    mc_we = 1'b1;
    tick(8);
    check("short_we_max_one", ((wr_cnt - wr_base) <= 1) ? 32'd1 : 32'd0, 32'd1);
    mc_ce = 1'b1;
    tick(4);

    // ce_n rises before we_n: aborted, no commit
    mc_ce = 1'b0; mc_add = REG_IO_HLDIR;
    tick(1);
    wr_base = wr_cnt;
    mc_we = 1'b0;
    tick(6);
    mc_ce = 1'b1;
    tick(4);
    mc_we = 1'b1;
    tick(6);
    check("abort_no_write", wr_cnt - wr_base, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_bus_responder.md
# mc_bus_responder

Responder side of the MCU parallel memory bus (mc_ce / mc_oe / mc_we / mc_add / mc_data) inside `top`. It synchronises the asynchronous active-low strobes from the MCU and turns each completed write cycle into a one-clock register-write strobe. It turns each read cycle into a one-clock read request, then drives the returned word onto mc_data for the rest of the read. It is the single point through which the MCU reaches the IO-pin, SRAM, LA-count and PWM registers.

## Interface
- MC_DATA_WIDTH, 16: bus data width
- MC_ADD_WIDTH, 6: bus address width
- Reset is synchronous and active-high; the clock port is `clock` and the reset port is `reset`.
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- mc_ce  in  1  chip enable, active-low, asynchronous
- mc_oe  in  1  output enable (read strobe), active-low, asynchronous
- mc_we  in  1  write enable (write strobe), active-low, asynchronous
- mc_add  in  MC_ADD_WIDTH  address, asynchronous
- mc_data  inout  MC_DATA_WIDTH  data; driven only while a read is in progress, else high-Z
- reg_wr_en  out  1  one-cycle write strobe
- reg_wr_addr  out  MC_ADD_WIDTH  write address, valid with reg_wr_en
- reg_wr_data  out  MC_DATA_WIDTH  write data, valid with reg_wr_en
- reg_rd_en  out  1  one-cycle read request; side-effecting registers (e.g. SRAM data, 0x02) pop on it
- reg_rd_addr  out  MC_ADD_WIDTH  read address, valid with reg_rd_en
- reg_rd_data  in  MC_DATA_WIDTH  read data, valid exactly 1 cycle after reg_rd_en
- bus_err  out  1  sticky: write and read strobes overlapped

## Operation
- Synchronisation:
  - ce_n, oe_n and we_n each pass through 2 flops and then a third edge-detect flop; all three stages reset to 1 (inactive).
  - mc_add and mc_data pass through 2 flops; these reset to 0.
- States: IDLE, WRITE, READ_REQ, READ_WAIT, READ_DRIVE.
- IDLE -> WRITE: synced we_n = 0 and ce_n = 0. Address and data keep being sampled every cycle while in WRITE.
- WRITE -> IDLE on synced we_n rising:
  - assert reg_wr_en for 1 cycle;
  - reg_wr_addr / reg_wr_data carry the address and data sampled in the last cycle we_n was low.
- WRITE -> IDLE without commit: synced ce_n rises before we_n rises.
- IDLE -> READ_REQ: synced oe_n = 0, ce_n = 0, we_n = 1.
- READ_REQ: reg_rd_en = 1 with reg_rd_addr = synced address; next state READ_WAIT.
- READ_WAIT: capture reg_rd_data into the hold register; next state READ_DRIVE.
- READ_DRIVE:
  - mc_data driven from the hold register;
  - exit to IDLE when synced oe_n = 1 or ce_n = 1, and release mc_data in that same cycle.
- Exactly one reg_rd_en per oe_n low pulse, regardless of pulse length.
- Overlap: we_n and oe_n both low in IDLE → write wins, bus_err set, no read issued. oe_n falling while in WRITE → bus_err set, ignored.
- bus_err clears only on reset.
- mc_data drive enable comes from a registered state decode only; it is never combinational from the pins.

## Timing
- Reset values:
  - outputs: reg_wr_en = 0, reg_rd_en = 0, reg_wr_addr = 0, reg_wr_data = 0, reg_rd_addr = 0, bus_err = 0, mc_data high-Z;
  - internal: state IDLE, hold register 0.
- Write latency: 3 cycles from we_n rising at the pin to reg_wr_en high.
- Read request latency: 3 cycles from oe_n falling at the pin to reg_rd_en high.
- Bus drive: mc_data is driven 5 cycles after oe_n falls, and released 3 cycles after oe_n rises.
- Minimum strobe low and high widths: 4 clocks each. Shorter pulses may be missed and must never produce more than one strobe.
- Address and data must be stable from 3 cycles before we_n rises.
- Reset mid-cycle:
  - return to IDLE and tri-state immediately; no strobe in the reset cycle;
  - because the sync stages reset to 1, a strobe still held low after reset release starts a fresh cycle, with no phantom commit.
- Back-to-back cycles: a new strobe may be detected in the cycle after IDLE is re-entered.

## Structure
- Package `mc_bus_pkg`:
  - parameter defaults;
  - state enum;
  - register address map constants: IO_ODOE 0x00, IO_HLDIR 0x01, SRAM_DATA 0x02, SRAM_CTRL 0x03, LA_COUNT 0x04, PWM_A 0x05, PWM_B 0x06.
- One sub-module, `sync_edge`: 2-flop synchroniser with reset-to-1 and an edge-detect stage, outputs `rise` and `fall`. Instantiated for ce_n, oe_n and we_n.

## Test plan
- Write 0x001B to addr 0x03 with a 6-cycle we_n low → exactly one reg_wr_en, addr 0x03, data 0x001B, 3 cycles after we_n rises.
- Read addr 0x02, bench returning 0xAA then 0x55 on two reads → reg_rd_en pulses once per read; mc_data shows 0x00AA, then 0x0055, each high-Z 3 cycles after oe_n rises.
- oe_n held low for 200 cycles → exactly one reg_rd_en.
- we_n and oe_n pulled low together → one write, no reg_rd_en, bus_err = 1 until reset.
- Reset asserted during READ_DRIVE, with oe_n kept low → mc_data high-Z next cycle; after release, exactly one new reg_rd_en, no reg_wr_en.
- we_n low pulse of 1 cycle → at most one reg_wr_en and never two; ce_n rising before we_n → no reg_wr_en.
